// File: rtl/axis_traffic_pkg.sv
// Shared constants and helpers for the AXI-Stream bulk traffic checker.
// Holds pattern encodings, LFSR polynomial and generator state encoding.
package axis_traffic_pkg;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hACE1;

    localparam int PAT_COUNT = 0;
    localparam int PAT_LFSR = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } gen_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic logic [15:0] sat_add(
        input logic [15:0] v,
        input logic [1:0] n
    );
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/axis_pattern_gen.sv
// Payload pattern generator shared by the tx source and rx checker.
// Counter or LFSR; steps only when advance is high.
import axis_traffic_pkg::*;

module axis_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int PATTERN = PAT_COUNT,
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] data
);

    if (PATTERN == PAT_COUNT) begin : g_cnt
        logic [WIDTH-1:0] cnt;

        // Count accepted beats; continuous across packets
        always_ff @(posedge clock) begin
            if (reset || load) begin
                cnt <= '0;
            end else if (advance) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign data = cnt;
    end else begin : g_lfsr
        logic [15:0] state;
        logic [15:0] step1;
        logic [15:0] step2;

        assign step1 = lfsr_next(state);
        assign step2 = lfsr_next(step1);

        // Wide words consume two LFSR steps per beat
        always_ff @(posedge clock) begin
            if (reset || load) begin
                state <= SEED;
            end else if (advance) begin
                state <= (WIDTH == 32) ? step2 : step1;
            end
        end

        if (WIDTH == 32) begin : g_w32
            assign data = {state, step1};
        end else begin : g_narrow
            assign data = state[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/axis_bulk_traffic_chk.sv
// AXI-Stream traffic source and loopback checker for the bulk data path.
// Source emits counted packets; sink checks data, framing and counts.
import axis_traffic_pkg::*;

module axis_bulk_traffic_chk #(
    parameter int WIDTH = 8,
    parameter int PACKET_MODE = 1,
    parameter int PATTERN = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int GAP_CYCLES = 2,
    parameter logic [7:0] READY_PATTERN = 8'hFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [9:0]       pkt_len_i,
    input  logic [15:0]      pkt_count_i,
    output logic             m_axis_tvalid_o,
    input  logic             m_axis_tready_i,
    output logic             m_axis_tlast_o,
    output logic [WIDTH-1:0] m_axis_tdata_o,
    input  logic             s_axis_tvalid_i,
    output logic             s_axis_tready_o,
    input  logic             s_axis_tlast_i,
    input  logic [WIDTH-1:0] s_axis_tdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      tx_pkts_o,
    output logic [15:0]      rx_pkts_o,
    output logic [15:0]      err_count_o,
    output logic             err_o
);

    gen_state_e state;
    logic [9:0] len_q;
    logic [9:0] tx_beat;
    logic [9:0] rx_beat;
    logic [15:0] cnt_q;
    logic [15:0] gap_cnt;
    logic [15:0] tx_pkts;
    logic [15:0] rx_pkts;
    logic [15:0] err_count;
    logic [15:0] tx_pkts_inc;
    logic stop_pend;
    logic stop_now;
    logic tvalid;
    logic busy;
    logic done;
    logic err;
    logic idle_rdy;
    logic [2:0] k;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic start_ok;
    logic tx_hs;
    logic tx_last;
    logic rx_chk;
    logic data_err;
    logic len_err;
    logic rx_end;
    logic [1:0] err_inc;

    assign start_ok = start_i && (state == ST_IDLE);
    assign tx_hs = tvalid && m_axis_tready_i;
    assign tx_last = (tx_beat == len_q - 10'd1);
    assign tx_pkts_inc = sat_add(tx_pkts, 2'd1);
    assign stop_now = stop_pend || stop_i;

    assign rx_chk = busy && s_axis_tvalid_i && s_axis_tready_o;
    assign data_err = rx_chk && (s_axis_tdata_i != rx_data);
    assign len_err = (PACKET_MODE != 0) && rx_chk &&
        (s_axis_tlast_i != (rx_beat == len_q - 10'd1));
    assign rx_end = (PACKET_MODE != 0) ? s_axis_tlast_i
        : (rx_beat == len_q - 10'd1);
    assign err_inc = {1'b0, data_err} + {1'b0, len_err};

    axis_pattern_gen #(
        .WIDTH(WIDTH),
        .PATTERN(PATTERN),
        .SEED(LFSR_SEED)
    ) u_tx_gen (
        .clock(clock),
        .reset(reset),
        .load(start_ok),
        .advance(tx_hs),
        .data(tx_data)
    );

    axis_pattern_gen #(
        .WIDTH(WIDTH),
        .PATTERN(PATTERN),
        .SEED(LFSR_SEED)
    ) u_rx_gen (
        .clock(clock),
        .reset(reset),
        .load(start_ok),
        .advance(rx_chk),
        .data(rx_data)
    );

    // Generator FSM: sequences packets, gaps and run completion
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            len_q <= '0;
            cnt_q <= '0;
            tx_beat <= '0;
            gap_cnt <= '0;
            tx_pkts <= '0;
            stop_pend <= 1'b0;
            tvalid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q <= pkt_len_i;
                        cnt_q <= pkt_count_i;
                        tx_beat <= '0;
                        tx_pkts <= '0;
                        stop_pend <= 1'b0;
                        done <= 1'b0;
                        busy <= 1'b1;
                        if (pkt_len_i == '0 || pkt_count_i == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_SEND;
                            tvalid <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (stop_i) begin
                        stop_pend <= 1'b1;
                    end
                    if (tx_hs) begin
                        if (tx_last) begin
                            tx_beat <= '0;
                            tx_pkts <= tx_pkts_inc;
                            if (tx_pkts_inc == cnt_q || stop_now) begin
                                state <= ST_DONE;
                                tvalid <= 1'b0;
                            end else if (GAP_CYCLES != 0) begin
                                state <= ST_GAP;
                                tvalid <= 1'b0;
                                gap_cnt <= '0;
                            end
                        end else begin
                            tx_beat <= tx_beat + 10'd1;
                            if (PACKET_MODE == 0 && stop_now) begin
                                state <= ST_DONE;
                                tvalid <= 1'b0;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (stop_now) begin
                        state <= ST_DONE;
                    end else if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
                        state <= ST_SEND;
                        tvalid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (rx_pkts == tx_pkts) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Checker: compare sink beats against the rx pattern and framing
    always_ff @(posedge clock) begin
        if (reset || start_ok) begin
            rx_pkts <= '0;
            rx_beat <= '0;
            err_count <= '0;
            err <= 1'b0;
        end else if (rx_chk) begin
            err_count <= sat_add(err_count, err_inc);
            if (data_err || len_err) begin
                err <= 1'b1;
            end
            if (rx_end) begin
                rx_beat <= '0;
                rx_pkts <= sat_add(rx_pkts, 2'd1);
            end else begin
                rx_beat <= rx_beat + 10'd1;
            end
        end
    end

    // Rotating sink back-pressure index, reset at each run start
    always_ff @(posedge clock) begin
        if (reset) begin
            k <= '0;
            idle_rdy <= READY_PATTERN[0];
        end else begin
            idle_rdy <= 1'b1;
            if (start_ok) begin
                k <= '0;
            end else if (busy) begin
                k <= k + 3'd1;
            end
        end
    end

    assign s_axis_tready_o = busy ? READY_PATTERN[k] : idle_rdy;

    assign m_axis_tvalid_o = tvalid;
    assign m_axis_tlast_o = (PACKET_MODE != 0) && tvalid && tx_last;
    assign m_axis_tdata_o = tvalid ? tx_data : '0;
    assign busy_o = busy;
    assign done_o = done;
    assign tx_pkts_o = tx_pkts;
    assign rx_pkts_o = rx_pkts;
    assign err_count_o = err_count;
    assign err_o = err;

endmodule

// File: doc/axis_bulk_traffic_chk.md
Name: axis_bulk_traffic_chk

Overview:
Synthesisable AXI-Stream traffic generator and loopback checker for the bulk-endpoint data path. It replaces hand-driven svalid/slast/sdata stimulus in benches and doubles as an on-FPGA self-test.
- Source side drives the core's s_axis input.
- Sink side consumes the core's m_axis output or a loopback of it.
- Generalised over data width, payload pattern, packet/stream mode, inter-packet gap and sink back-pressure.

Parameters:
WIDTH, 8, data width in bits (8, 16 or 32)
PACKET_MODE, 1, 1: tlast ends each packet; 0: tlast never driven and ignored by the checker
PATTERN, 0, 0: incrementing counter; 1: 16-bit LFSR (x^16+x^14+x^13+x^11+1)
LFSR_SEED, 16'hACE1, LFSR reset/start value (must be non-zero)
GAP_CYCLES, 2, idle cycles between packets (0 allowed)
READY_PATTERN, 8'hFF, rotating tready mask for the sink

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
start_i  in  1  1-cycle pulse: begin a run
stop_i  in  1  end the run at the next packet boundary
pkt_len_i  in  10  beats per packet, sampled at start
pkt_count_i  in  16  packets per run, sampled at start
m_axis_tvalid_o  out  1  source valid
m_axis_tready_i  in  1  source ready
m_axis_tlast_o  out  1  source last
m_axis_tdata_o  out  WIDTH  source data
s_axis_tvalid_i  in  1  sink valid
s_axis_tready_o  out  1  sink ready
s_axis_tlast_i  in  1  sink last
s_axis_tdata_i  in  WIDTH  sink data
busy_o  out  1  run in progress
done_o  out  1  level: run complete, cleared by start
tx_pkts_o  out  16  packets fully sent
rx_pkts_o  out  16  packets fully received
err_count_o  out  16  data and length errors, saturating
err_o  out  1  sticky: any error since start

Behaviour:
- Reset values:
  - All outputs 0, except s_axis_tready_o = READY_PATTERN[0].
  - Pattern generators reload (counter 0, LFSR LFSR_SEED).
- Reset mid-run aborts immediately; no partial state survives.
- Generator FSM:
  - IDLE -> SEND on start_i while not busy; start_i while busy is ignored.
  - start_i clears counters, err_o and done_o, and reloads both the tx and rx pattern generators.
  - pkt_len_i==0 or pkt_count_i==0: go straight to DONE; done_o rises 2 cycles after start_i.
  - SEND: m_axis_tvalid_o=1. On each handshake (tvalid & tready) advance the beat index and pattern.
  - tlast = PACKET_MODE & (beat == pkt_len-1).
  - Last beat accepted: tx_pkts++. Then go to DONE if tx_pkts==pkt_count or stop is pending, else to GAP (or straight back to SEND if GAP_CYCLES==0).
  - GAP: counts GAP_CYCLES with tvalid=0, then returns to SEND.
  - DONE: waits for the checker (rx_pkts==tx_pkts) and sets done_o; busy_o drops in the same cycle.
  - PACKET_MODE=0 and stop_i while sending: the current handshake completes, then DONE.
- AXIS source rules:
  - Once tvalid is high, tdata, tlast and tvalid stay stable until tready.
  - No combinational path from tready to tvalid.
- Data pattern:
  - Counter mode: beat n of the run carries n mod 2^WIDTH; the count is continuous across packets.
  - LFSR mode: tdata is the low WIDTH bits of the LFSR state. For WIDTH=32 the word is {state, next-state}, and the LFSR advances twice per beat.
- Checker:
  - s_axis_tready_o = READY_PATTERN[k], where k is a 3-bit free-running counter that rotates every cycle while busy; the output is 1 when not busy.
  - Keeps an independent expected-pattern generator that advances only on sink handshakes, with no resync.
  - tdata != expected: err_count++ (one per beat).
  - PACKET_MODE=1: tlast must match rx beat == pkt_len-1, else err_count++. A received tlast always ends the rx packet (rx_pkts++) and resets the rx beat index.
  - Beats received while not busy are accepted and ignored.
- Counters:
  - err_count_o and tx/rx counters saturate at 16'hFFFF.
  - Data and length error on the same beat counts 2.
  - err_o is set on any error and stays set until the next start_i.

Decomposition:
Shared package axis_traffic_pkg holds:
- LFSR polynomial tap constant and default seed.
- Pattern mode encodings.
- Generator state encoding (IDLE, SEND, GAP, DONE).

One sub-module, axis_pattern_gen (WIDTH, PATTERN, SEED; inputs clock, reset, load, advance; output data). It is instanced twice, once for tx and once for rx, so both sides share one implementation.

Test Plan:
1. WIDTH=8, counter mode, loopback, pkt_len=4, pkt_count=2:
   - Source emits 00,01,02,03(last), 2-cycle gap, 04..07(last).
   - Response: rx_pkts=2, err_count=0, done_o=1, busy_o=0.
2. Same run with the bench flipping bit 0 of sink beat 5 (05 -> 04):
   - err_count=1, err_o=1; beats 6 and 7 do not add errors.
3. READY_PATTERN=8'hAA, pkt_len=8, pkt_count=1:
   - Sink data matches; the 8 beats take at least 16 cycles; err_count=0.
   - Source tdata held stable across all stalls (assertion).
4. PACKET_MODE=1, bench suppresses tlast on rx beat 3 of a pkt_len=4 run:
   - err_count at least 1; rx_pkts stays 0 until the next received tlast.
5. Control corner cases:
   - pkt_count=0: done_o rises 2 cycles after start_i, with no tvalid.
   - stop_i during packet 1 of 5 (pkt_len=4): tx_pkts=1 after the boundary, then done.
6. Reset asserted mid-packet in LFSR mode, then restart:
   - All outputs return to reset values.
   - The first beat after the new start equals the low WIDTH bits of LFSR_SEED.
   - The run completes with err_count=0.
